// File: rtl/bnn_pkg.sv
// Shared widths, weight-word type and sizing helpers for the binary convolution stage.
// Build option BNN_CONV_THRESH_FLIP_EN adds a per-filter output polarity bit.
package bnn_pkg;

   localparam int unsigned NO_CH_DEF       = 2;
   localparam int unsigned WINDOW_SIZE_DEF = 3;
   localparam int unsigned SER_CYC_DEF     = 1;
   localparam int unsigned NO_FILT_DEF     = 4;

`ifdef BNN_CONV_THRESH_FLIP_EN
   localparam int unsigned FLIP_W = 1;
`else
   localparam int unsigned FLIP_W = 0;
`endif

   typedef logic [WINDOW_SIZE_DEF*NO_CH_DEF-1:0] weight_word_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned pc_w(input int unsigned n_bits);
      return $clog2(n_bits + 1);
   endfunction

   function automatic int unsigned acc_w(input int unsigned ws, input int unsigned ch,
                                         input int unsigned ser);
      return $clog2(ws * ch * ser + 1);
   endfunction

endpackage

// File: rtl/popcount_tree.sv
// Registered population count of an N_BITS-wide vector.
module popcount_tree import bnn_pkg::*; #(
   parameter int unsigned N_BITS = 6,
   localparam int unsigned CNT_W = pc_w(N_BITS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_BITS-1:0] bits_in,
   output logic [CNT_W-1:0]  count_out
);

   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;

   always_comb begin
      count_d = '0;
      for (int unsigned i = 0; i < N_BITS; i++) begin
         count_d = count_d + CNT_W'(bits_in[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_out = count_q;

endmodule

// File: rtl/bnn_conv_serial.sv
// XNOR-popcount 1-D convolution: accumulates SER_CYC channel slices per position, then thresholds.
// Build option BNN_CONV_THRESH_FLIP_EN widens wr_thresh by one flip bit per filter.
module bnn_conv_serial import bnn_pkg::*; #(
   parameter int unsigned NO_CH       = NO_CH_DEF,
   parameter int unsigned WINDOW_SIZE = WINDOW_SIZE_DEF,
   parameter int unsigned SER_CYC     = SER_CYC_DEF,
   parameter int unsigned NO_FILT     = NO_FILT_DEF,
   localparam int unsigned WW     = WINDOW_SIZE * NO_CH,
   localparam int unsigned ACC_W  = acc_w(WINDOW_SIZE, NO_CH, SER_CYC),
   localparam int unsigned TH_W   = ACC_W + FLIP_W,
   localparam int unsigned FILT_W = clog2_min1(NO_FILT),
   localparam int unsigned SER_W  = clog2_min1(SER_CYC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld_in,
   input  logic [NO_CH-1:0]   win_in [WINDOW_SIZE],
   input  logic               last_in,
   input  logic               wr_en,
   input  logic [FILT_W-1:0]  wr_filt,
   input  logic [SER_W-1:0]   wr_ser,
   input  logic [WW-1:0]      wr_weight,
   input  logic [TH_W-1:0]    wr_thresh,
   output logic               vld_out,
   output logic [NO_FILT-1:0] data_out,
   output logic               err
);

   localparam int unsigned PC_W   = pc_w(WW);
   localparam int unsigned FILT_D = 1 << FILT_W;
   localparam int unsigned SER_D  = 1 << SER_W;
   localparam logic [SER_W-1:0] SER_LAST = SER_W'(SER_CYC - 1);

   logic [SER_W-1:0]   ser_idx_d, ser_idx_q;
   logic               err_d, err_q;
   logic               s1_vld_d, s1_vld_q;
   logic               s1_last_d, s1_last_q;
   logic               vld_out_d, vld_out_q;
   logic [NO_FILT-1:0] data_out_d, data_out_q;
   logic [WW-1:0]      weight_d [FILT_D][SER_D];
   logic [WW-1:0]      weight_q [FILT_D][SER_D];
   logic [ACC_W-1:0]   thresh_d [FILT_D];
   logic [ACC_W-1:0]   thresh_q [FILT_D];
`ifdef BNN_CONV_THRESH_FLIP_EN
   logic [FILT_D-1:0]  flip_d, flip_q;
`endif
   logic [ACC_W-1:0]   acc_d [NO_FILT];
   logic [ACC_W-1:0]   acc_q [NO_FILT];
   logic [ACC_W-1:0]   sum [NO_FILT];
   logic [PC_W-1:0]    pc [NO_FILT];
   logic [NO_FILT-1:0] hit;
   logic [WW-1:0]      win_flat;

   // Tap t occupies bits [t*NO_CH +: NO_CH], matching the weight word layout.
   always_comb begin
      win_flat = '0;
      for (int unsigned t = 0; t < WINDOW_SIZE; t++) begin
         win_flat[t*NO_CH +: NO_CH] = win_in[t];
      end
   end

   for (genvar f = 0; f < NO_FILT; f++) begin : g_filt
      logic [WW-1:0] match;
      assign match = ~(win_flat ^ weight_q[f][ser_idx_q]);

      popcount_tree #(.N_BITS(WW)) u_pc (
         .clk       (clk),
         .rst       (rst),
         .bits_in   (match),
         .count_out (pc[f])
      );

      assign sum[f] = acc_q[f] + ACC_W'(pc[f]);
`ifdef BNN_CONV_THRESH_FLIP_EN
      assign hit[f] = (sum[f] >= thresh_q[f]) ^ flip_q[f];
`else
      assign hit[f] = (sum[f] >= thresh_q[f]);
`endif
   end

   // Slice sequencing and framing check on the incoming beat.
   always_comb begin
      ser_idx_d = ser_idx_q;
      err_d     = err_q;
      s1_vld_d  = vld_in;
      s1_last_d = vld_in & last_in;
      if (vld_in) begin
         if (last_in) begin
            ser_idx_d = '0;
            if (ser_idx_q != SER_LAST) err_d = 1'b1;
         end else if (ser_idx_q == SER_LAST) begin
            ser_idx_d = '0;
            err_d     = 1'b1;
         end else begin
            ser_idx_d = ser_idx_q + SER_W'(1);
         end
      end
   end

   always_comb begin
      weight_d = weight_q;
      thresh_d = thresh_q;
`ifdef BNN_CONV_THRESH_FLIP_EN
      flip_d   = flip_q;
`endif
      if (wr_en) begin
         weight_d[wr_filt][wr_ser] = wr_weight;
         thresh_d[wr_filt]         = wr_thresh[ACC_W-1:0];
`ifdef BNN_CONV_THRESH_FLIP_EN
         flip_d[wr_filt]           = wr_thresh[ACC_W];
`endif
      end
   end

   // Accumulate and, on the closing beat, compare using the sum that includes it.
   always_comb begin
      acc_d      = acc_q;
      vld_out_d  = 1'b0;
      data_out_d = data_out_q;
      if (s1_vld_q) begin
         for (int unsigned f = 0; f < NO_FILT; f++) begin
            acc_d[f] = s1_last_q ? '0 : sum[f];
         end
         if (s1_last_q) begin
            vld_out_d  = 1'b1;
            data_out_d = hit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ser_idx_q  <= '0;
         err_q      <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         vld_out_q  <= 1'b0;
         data_out_q <= '0;
         for (int unsigned f = 0; f < NO_FILT; f++) acc_q[f] <= '0;
      end else begin
         ser_idx_q  <= ser_idx_d;
         err_q      <= err_d;
         s1_vld_q   <= s1_vld_d;
         s1_last_q  <= s1_last_d;
         vld_out_q  <= vld_out_d;
         data_out_q <= data_out_d;
         acc_q      <= acc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned f = 0; f < FILT_D; f++) begin
            thresh_q[f] <= '0;
            for (int unsigned s = 0; s < SER_D; s++) weight_q[f][s] <= '0;
         end
`ifdef BNN_CONV_THRESH_FLIP_EN
         flip_q <= '0;
`endif
      end else begin
         weight_q <= weight_d;
         thresh_q <= thresh_d;
`ifdef BNN_CONV_THRESH_FLIP_EN
         flip_q   <= flip_d;
`endif
      end
   end

   assign vld_out  = vld_out_q;
   assign data_out = data_out_q;
   assign err      = err_q;

endmodule

// File: tb/tb_bnn_conv_serial.sv
// Directed bench for bnn_conv_serial: one instance with SER_CYC=1 (a_*) and one with SER_CYC=4 (b_*).
module tb_bnn_conv_serial;
   import bnn_pkg::*;

   localparam int unsigned A_TH_W = 3 + FLIP_W;
   localparam int unsigned B_TH_W = 5 + FLIP_W;

   logic clk;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned a_nout = 0;
   int unsigned b_nout = 0;
   int unsigned n0;

   logic              a_rst, a_vld, a_last, a_wr_en, a_vld_out, a_err;
   logic [1:0]        a_win [3];
   logic [1:0]        a_wr_filt;
   logic [0:0]        a_wr_ser;
   logic [5:0]        a_wr_weight;
   logic [A_TH_W-1:0] a_wr_thresh;
   logic [3:0]        a_data_out;

   logic              b_rst, b_vld, b_last, b_wr_en, b_vld_out, b_err;
   logic [1:0]        b_win [3];
   logic [1:0]        b_wr_filt;
   logic [1:0]        b_wr_ser;
   logic [5:0]        b_wr_weight;
   logic [B_TH_W-1:0] b_wr_thresh;
   logic [3:0]        b_data_out;

   bnn_conv_serial #(.NO_CH(2), .WINDOW_SIZE(3), .SER_CYC(1), .NO_FILT(4)) u_a (
      .clk(clk), .rst(a_rst), .vld_in(a_vld), .win_in(a_win), .last_in(a_last),
      .wr_en(a_wr_en), .wr_filt(a_wr_filt), .wr_ser(a_wr_ser), .wr_weight(a_wr_weight),
      .wr_thresh(a_wr_thresh), .vld_out(a_vld_out), .data_out(a_data_out), .err(a_err)
   );

   bnn_conv_serial #(.NO_CH(2), .WINDOW_SIZE(3), .SER_CYC(4), .NO_FILT(4)) u_b (
      .clk(clk), .rst(b_rst), .vld_in(b_vld), .win_in(b_win), .last_in(b_last),
      .wr_en(b_wr_en), .wr_filt(b_wr_filt), .wr_ser(b_wr_ser), .wr_weight(b_wr_weight),
      .wr_thresh(b_wr_thresh), .vld_out(b_vld_out), .data_out(b_data_out), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (a_vld_out === 1'b1) a_nout++;
      if (b_vld_out === 1'b1) b_nout++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic a_drive(input weight_word_t w, input logic v, input logic l);
      for (int t = 0; t < 3; t++) a_win[t] = w[t*2 +: 2];
      a_vld  = v;
      a_last = l;
   endtask

   task automatic b_drive(input weight_word_t w, input logic v, input logic l);
      for (int t = 0; t < 3; t++) b_win[t] = w[t*2 +: 2];
      b_vld  = v;
      b_last = l;
   endtask

   task automatic a_write(input int f, input weight_word_t w, input int t);
      a_wr_en = 1'b1; a_wr_filt = 2'(f); a_wr_ser = 1'b0;
      a_wr_weight = w; a_wr_thresh = A_TH_W'(t);
      tick();
      a_wr_en = 1'b0;
   endtask

   task automatic b_write(input int f, input int s, input weight_word_t w, input int t);
      b_wr_en = 1'b1; b_wr_filt = 2'(f); b_wr_ser = 2'(s);
      b_wr_weight = w; b_wr_thresh = B_TH_W'(t);
      tick();
      b_wr_en = 1'b0;
   endtask

   // Single-beat position on the SER_CYC=1 instance, checking latency and hold.
   task automatic a_pos(input weight_word_t w, input logic [3:0] exp, input string tag);
      a_drive(w, 1'b1, 1'b1);
      tick();
      a_drive('0, 1'b0, 1'b0);
      check({tag, "_lat1"}, a_vld_out, 0);
      tick();
      check({tag, "_vld"}, a_vld_out, 1);
      check({tag, "_data"}, a_data_out, exp);
      tick();
      check({tag, "_pulse"}, a_vld_out, 0);
      check({tag, "_hold"}, a_data_out, exp);
   endtask

   task automatic b_beat(input logic l);
      b_drive(6'b000111, 1'b1, l);
      tick();
      b_drive('0, 1'b0, 1'b0);
   endtask

   // Four back-to-back beats (window 000111) closing one position.
   task automatic b_run4(input logic [3:0] exp, input string tag);
      b_beat(1'b0);
      b_beat(1'b0);
      b_beat(1'b0);
      b_beat(1'b1);
      check({tag, "_lat1"}, b_vld_out, 0);
      tick();
      check({tag, "_vld"}, b_vld_out, 1);
      check({tag, "_data"}, b_data_out, exp);
      tick();
   endtask

   initial begin
      a_rst = 1'b1; b_rst = 1'b1;
      a_wr_en = 1'b0; a_wr_filt = '0; a_wr_ser = '0; a_wr_weight = '0; a_wr_thresh = '0;
      b_wr_en = 1'b0; b_wr_filt = '0; b_wr_ser = '0; b_wr_weight = '0; b_wr_thresh = '0;
      a_drive('0, 1'b0, 1'b0);
      b_drive('0, 1'b0, 1'b0);
      tick();
      tick();
      a_rst = 1'b0; b_rst = 1'b0;
      check("a_rst_vld", a_vld_out, 0);
      check("a_rst_data", a_data_out, 0);
      check("a_rst_err", a_err, 0);
      check("b_rst_vld", b_vld_out, 0);
      check("b_rst_data", b_data_out, 0);
      check("b_rst_err", b_err, 0);

      // SER_CYC=1: one beat per position
      a_write(0, 6'b000000, 4);
      a_write(1, 6'b111111, 6);
      a_write(2, 6'b010101, 4);
      a_write(3, 6'b000000, 5);
      a_pos(6'b000000, 4'b1001, "a_zero");
      a_pos(6'b111111, 4'b0010, "a_ones");
      a_pos(6'b010101, 4'b0100, "a_alt");
      a_pos(6'b000011, 4'b0001, "a_eq");
      check("a_err_clean", a_err, 0);

      // Weight write colliding with a beat that reads the same entry
      a_wr_en = 1'b1; a_wr_filt = 2'd1; a_wr_ser = 1'b0;
      a_wr_weight = 6'b000000; a_wr_thresh = A_TH_W'(6);
      a_drive(6'b111111, 1'b1, 1'b1);
      tick();
      a_wr_en = 1'b0;
      tick();
      a_drive('0, 1'b0, 1'b0);
      check("a_wr_old_vld", a_vld_out, 1);
      check("a_wr_old_data", a_data_out, 4'b0010);
      tick();
      check("a_wr_new_vld", a_vld_out, 1);
      check("a_wr_new_data", a_data_out, 4'b0000);
      tick();

`ifdef BNN_CONV_THRESH_FLIP_EN
      a_write(0, 6'b000000, 4 + 8);
      a_pos(6'b000000, 4'b1010, "a_flip");
`endif

      // SER_CYC=1 beat without last_in is a framing error and yields no output
      n0 = a_nout;
      a_drive(6'b000000, 1'b1, 1'b0);
      tick();
      a_drive('0, 1'b0, 1'b0);
      tick();
      tick();
      check("a_err_nolast", a_err, 1);
      check("a_nolast_noout", a_nout - n0, 0);

      // SER_CYC=4 weights: f2/f3 only match on one specific slice
      b_write(0, 0, 6'b000000, 12);
      b_write(1, 0, 6'b000000, 13);
      b_write(2, 0, 6'b111000, 6);
      b_write(2, 1, 6'b111000, 6);
      b_write(2, 2, 6'b111000, 6);
      b_write(2, 3, 6'b000111, 6);
      b_write(3, 0, 6'b000111, 7);
      b_write(3, 1, 6'b111000, 7);
      b_write(3, 2, 6'b111000, 7);
      b_write(3, 3, 6'b111000, 7);

      // Position with a 2-cycle gap after beat 1; stray last_in without vld_in in the gap
      n0 = b_nout;
      b_beat(1'b0);
      b_drive(6'b000111, 1'b0, 1'b1);
      tick();
      b_drive('0, 1'b0, 1'b0);
      tick();
      b_beat(1'b0);
      b_beat(1'b0);
      b_beat(1'b1);
      check("b_gap_lat1", b_vld_out, 0);
      tick();
      check("b_gap_vld", b_vld_out, 1);
      check("b_gap_data", b_data_out, 4'b0101);
      tick();
      check("b_gap_one_pulse", b_nout - n0, 1);
      check("b_gap_hold", b_data_out, 4'b0101);

      b_write(0, 0, 6'b000000, 13);
      b_run4(4'b0100, "b_t13");
      check("b_err_clean", b_err, 0);

      // Early last_in on the second beat
      b_write(1, 0, 6'b000000, 6);
      b_beat(1'b0);
      b_beat(1'b1);
      tick();
      check("b_short_vld", b_vld_out, 1);
      check("b_short_data", b_data_out, 4'b0010);
      check("b_short_err", b_err, 1);
      tick();
      b_run4(4'b0110, "b_after_err");
      check("b_err_sticky", b_err, 1);

      // Reset mid-position discards the partial sum and in-flight beats
      n0 = b_nout;
      b_beat(1'b0);
      b_beat(1'b0);
      b_rst = 1'b1;
      tick();
      b_rst = 1'b0;
      check("b_mid_rst_err", b_err, 0);
      check("b_mid_rst_vld", b_vld_out, 0);
      check("b_mid_rst_data", b_data_out, 0);
      b_write(0, 0, 6'b000000, 13);
      b_write(1, 0, 6'b000000, 12);
      b_run4(4'b1110, "b_post_rst");
      tick();
      check("b_rst_one_pulse", b_nout - n0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
